dot_matrix_scheduler: RTL

Double-buffered scan controller for the 8x8 LED dot-matrix display. Owns an internal scan-rate prescaler, two 8x8 frame pages, and the row/column drive. A producer writes a back page row by row and requests a swap. The block swaps pages only at a frame boundary and acknowledges with a one-cycle pulse, so a displayed frame is never torn.

---
 rtl/dot_matrix_scheduler.sv | 95 +++++++++
 1 files changed

// File: rtl/dot_matrix_scheduler.sv
// dot_matrix_scheduler
// Double-buffered 8x8 LED dot-matrix scan controller. A prescaler produces a
// scan tick every SCAN_DIV+1 clocks; each tick loads one row of the front
// page onto the row/col drive. The producer fills the back page and requests
// a swap; the swap is taken only on the tick that loads row 7, so a frame is
// never torn.

module dot_matrix_scheduler #(
  parameter logic [31:0] SCAN_DIV = 32'd5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       swap_req,
  input  logic       blank,
  output logic       swap_ack,
  output logic       frame_start,
  output logic [7:0] row,
  output logic [7:0] col
);

  logic [31:0] cnt;
  logic [2:0]  ptr;
  logic        front;
  logic        back;
  logic        tick;
  logic        frame_end;
  logic [7:0]  page [2][8];

  assign tick      = (cnt == SCAN_DIV);
  assign back      = ~front;
  // The row-7 tick closes the frame; a swap taken here shows from the next row 0.
  assign frame_end = tick && (ptr == 3'd7);

  // Scan prescaler: wraps to zero on the same edge that raises a tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

  // Row pointer and registered row/col drive, updated only on ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      row <= 8'hFF;
      col <= 8'h00;
    end else if (tick) begin
      ptr <= ptr + 3'd1;
      row <= ~(8'b1 << ptr);
      col <= blank ? 8'h00 : page[front][ptr];
    end
  end

  // One-cycle status pulses; both are cleared on every non-qualifying edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_start <= 1'b0;
      swap_ack    <= 1'b0;
    end else begin
      frame_start <= tick && (ptr == 3'd0);
      swap_ack    <= frame_end && swap_req;
    end
  end

  // Page select: the request is sampled only at frame end, nothing is latched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      front <= 1'b0;
    end else if (frame_end && swap_req) begin
      front <= ~front;
    end
  end

  // Frame storage: writes always target the pre-edge back page, so a write
  // coinciding with a swap lands in the page that becomes displayed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin
        for (int r = 0; r < 8; r++) begin
          page[p][r] <= 8'h00;
        end
      end
    end else if (wr_en) begin
      page[back][wr_row] <= wr_data;
    end
  end

endmodule
